// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants on contention; default is data-first priority.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_enable,
    output logic [31:0] i_instruction,
    output logic        i_stall,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    output logic [31:0] d_readdata,
    output logic        d_stall,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_address,
    output logic [3:0]  m_byteenable,
    output logic [31:0] m_writedata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_m_req;
    logic        r_m_we;
    logic [31:0] r_m_address;
    logic [3:0]  r_m_byteenable;
    logic [31:0] r_m_writedata;

    logic        w_dreq;
    logic        w_grant_d;
    logic        w_ack_i;
    logic        w_ack_d;

    assign w_dreq  = d_read | d_write;
    assign w_ack_i = (r_state == BUSY_I) & m_ack;
    assign w_ack_d = (r_state == BUSY_D) & m_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Set when data won the most recent grant; cleared (fetch) out of reset.
    logic r_last_d;
    assign w_grant_d = w_dreq & (~i_enable | ~r_last_d);
`else
    assign w_grant_d = w_dreq;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_m_req        <= 1'b0;
            r_m_we         <= 1'b0;
            r_m_address    <= '0;
            r_m_byteenable <= '0;
            r_m_writedata  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_d       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state        <= BUSY_D;
                        r_m_req        <= 1'b1;
                        r_m_we         <= d_write;
                        r_m_address    <= d_address;
                        r_m_byteenable <= d_byteenable;
                        r_m_writedata  <= d_writedata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_d       <= 1'b1;
`endif
                    end else if (i_enable) begin
                        r_state        <= BUSY_I;
                        r_m_req        <= 1'b1;
                        r_m_we         <= 1'b0;
                        r_m_address    <= i_address;
                        r_m_byteenable <= 4'hF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_d       <= 1'b0;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Fields stay frozen until the ack; requester input changes are ignored.
                    if (m_ack) begin
                        r_state <= IDLE;
                        r_m_req <= 1'b0;
                        r_m_we  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_m_req <= 1'b0;
                    r_m_we  <= 1'b0;
                end
            endcase
        end
    end

    assign m_req         = r_m_req;
    assign m_we          = r_m_we;
    assign m_address     = r_m_address;
    assign m_byteenable  = r_m_byteenable;
    assign m_writedata   = r_m_writedata;

    assign i_stall       = i_enable & ~w_ack_i;
    assign d_stall       = w_dreq & ~w_ack_d;
    assign i_instruction = m_rdata;
    assign d_readdata    = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory transactions, a monitor checks the bus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_address;
    logic        i_enable;
    logic [31:0] i_instruction;
    logic        i_stall;
    logic [31:0] d_address;
    logic [3:0]  d_byteenable;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [31:0] d_readdata;
    logic        d_stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_address;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_enable(i_enable),
        .i_instruction(i_instruction), .i_stall(i_stall),
        .d_address(d_address), .d_byteenable(d_byteenable),
        .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_address(m_address),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_w;
        logic        own_d;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic push(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic chk_w, input logic own_d);
        exp_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.chk_w = chk_w; e.own_d = own_d;
        q.push_back(e);
    endtask

    // Memory responder: acks after ack_wait wait cycles, one-cycle pulses.
    int          ack_wait  = 0;
    bit          resp_en   = 1'b0;
    bit          late_ack  = 1'b0;
    int          wcnt      = 0;
    logic [31:0] rdata_seq = 32'hA000_0000;

    initial forever begin
        @(negedge clk);
        if (late_ack) begin
            m_ack    = 1'b1;
            m_rdata  = 32'hBAD0_BAD0;
            late_ack = 1'b0;
        end else if (m_ack) begin
            m_ack = 1'b0;
        end else if (!resp_en) begin
            wcnt = 0;
        end else if (m_req && !reset) begin
            if (wcnt >= ack_wait) begin
                m_ack     = 1'b1;
                m_rdata   = rdata_seq;
                rdata_seq = rdata_seq + 32'h0101_0011;
                wcnt      = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: compares the bus against the head of the scoreboard every busy cycle.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!reset && m_req) begin
            if (q.size() == 0) begin
                chk("unexpected_req", {31'b0, m_req}, 32'd0);
            end else begin
                e = q[0];
                chk("m_address", m_address, e.addr);
                chk("m_we", {31'b0, m_we}, {31'b0, e.we});
                chk("m_byteenable", {28'b0, m_byteenable}, {28'b0, e.be});
                if (e.chk_w) chk("m_writedata", m_writedata, e.wdata);
                if (m_ack) begin
                    e = q.pop_front();
                    if (e.own_d) begin
                        chk("d_readdata", d_readdata, m_rdata);
                        chk("d_stall_ack", {31'b0, d_stall}, 32'd0);
                        chk("i_stall_other", {31'b0, i_stall}, {31'b0, i_enable});
                    end else begin
                        chk("i_instruction", i_instruction, m_rdata);
                        chk("i_stall_ack", {31'b0, i_stall}, 32'd0);
                        chk("d_stall_other", {31'b0, d_stall}, {31'b0, d_read | d_write});
                    end
                end else begin
                    chk("i_stall_busy", {31'b0, i_stall}, {31'b0, i_enable});
                    chk("d_stall_busy", {31'b0, d_stall}, {31'b0, d_read | d_write});
                end
            end
        end
    end

    task automatic wait_ack(output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #3;
            n++;
            if (m_ack && m_req) return;
        end
        chk("ack_timeout", {31'b0, m_ack}, 32'd1);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        #3;
        chk("idle_mreq", {31'b0, m_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        i_address = '0; i_enable = 1'b1;
        d_address = '0; d_byteenable = '0; d_read = 1'b0; d_write = 1'b1; d_writedata = '0;

        // Reset state and stall pass-through while in reset
        repeat (2) @(negedge clk);
        #3;
        chk("rst_m_req", {31'b0, m_req}, 32'd0);
        chk("rst_m_we", {31'b0, m_we}, 32'd0);
        chk("rst_m_address", m_address, 32'd0);
        chk("rst_m_be", {28'b0, m_byteenable}, 32'd0);
        chk("rst_m_wdata", m_writedata, 32'd0);
        chk("rst_i_stall", {31'b0, i_stall}, 32'd1);
        chk("rst_d_stall", {31'b0, d_stall}, 32'd1);
        i_enable = 1'b0; d_write = 1'b0;
        #1;
        chk("rst_i_stall_lo", {31'b0, i_stall}, 32'd0);
        chk("rst_d_stall_lo", {31'b0, d_stall}, 32'd0);
        @(negedge clk);
        #3;
        reset = 1'b0;
        resp_en = 1'b1;
        idle_cycle();

        // Single fetch, immediate ack
        ack_wait = 0;
        i_address = 32'h100; i_enable = 1'b1;
        push(1'b0, 32'h100, 4'hF, '0, 1'b0, 1'b0);
        wait_ack(n);
        chk("fetch_latency", n, 32'd1);
        chk("fetch_istall", {31'b0, i_stall}, 32'd0);
        i_enable = 1'b0;
        idle_cycle();

        // Contention: fetch and load both held (last grant was fetch)
        i_address = 32'h400; i_enable = 1'b1;
        d_address = 32'h3000; d_byteenable = 4'hC; d_writedata = 32'h0; d_read = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push(1'b0, 32'h3000, 4'hC, 32'h0, 1'b1, 1'b1);
        push(1'b0, 32'h400, 4'hF, '0, 1'b0, 1'b0);
        push(1'b0, 32'h3000, 4'hC, 32'h0, 1'b1, 1'b1);
        push(1'b0, 32'h400, 4'hF, '0, 1'b0, 1'b0);
        repeat (4) wait_ack(n);
        d_read = 1'b0; i_enable = 1'b0;
`else
        push(1'b0, 32'h3000, 4'hC, 32'h0, 1'b1, 1'b1);
        push(1'b0, 32'h3000, 4'hC, 32'h0, 1'b1, 1'b1);
        push(1'b0, 32'h400, 4'hF, '0, 1'b0, 1'b0);
        push(1'b0, 32'h400, 4'hF, '0, 1'b0, 1'b0);
        repeat (2) wait_ack(n);
        d_read = 1'b0;
        repeat (2) wait_ack(n);
        i_enable = 1'b0;
`endif
        idle_cycle();

        // Store with 3 wait cycles
        ack_wait = 3;
        d_address = 32'h2004; d_byteenable = 4'b0011; d_writedata = 32'hDEAD_BEEF; d_write = 1'b1;
        push(1'b1, 32'h2004, 4'b0011, 32'hDEAD_BEEF, 1'b1, 1'b1);
        wait_ack(n);
        chk("store_cycles", n, 32'd4);
        d_write = 1'b0; ack_wait = 0;
        idle_cycle();

        // Read and write together: write wins
        d_address = 32'h40; d_byteenable = 4'hF; d_writedata = 32'h1234_5678;
        d_read = 1'b1; d_write = 1'b1;
        push(1'b1, 32'h40, 4'hF, 32'h1234_5678, 1'b1, 1'b1);
        wait_ack(n);
        d_read = 1'b0; d_write = 1'b0;
        idle_cycle();

        // Plain load
        d_address = 32'h80; d_byteenable = 4'h6; d_writedata = 32'h0; d_read = 1'b1;
        push(1'b0, 32'h80, 4'h6, 32'h0, 1'b1, 1'b1);
        wait_ack(n);
        d_read = 1'b0;
        idle_cycle();

        // Fetch address changes mid-transaction
        ack_wait = 3;
        i_address = 32'h200; i_enable = 1'b1;
        push(1'b0, 32'h200, 4'hF, '0, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        i_address = 32'h999;
        wait_ack(n);
        chk("addr_change_cycles", n, 32'd3);
        i_enable = 1'b0; ack_wait = 0;
        idle_cycle();

        // Reset in BUSY_D, late ack after release
        ack_wait = 100;
        d_address = 32'h5000; d_byteenable = 4'hF; d_writedata = 32'h0; d_read = 1'b1;
        push(1'b0, 32'h5000, 4'hF, 32'h0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        #3;
        chk("busyd_mreq", {31'b0, m_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_mreq", {31'b0, m_req}, 32'd0);
        chk("async_rst_maddr", m_address, 32'd0);
        chk("async_rst_dstall", {31'b0, d_stall}, 32'd1);
        q.delete();
        ack_wait = 0;
        push(1'b0, 32'h5000, 4'hF, 32'h0, 1'b1, 1'b1);
        late_ack = 1'b1;
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("late_ack_seen", {31'b0, m_ack}, 32'd1);
        chk("late_ack_mreq", {31'b0, m_req}, 32'd0);
        chk("late_ack_dstall", {31'b0, d_stall}, 32'd1);
        wait_ack(n);
        d_read = 1'b0;
        idle_cycle();
        idle_cycle();

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  clock, all state on rising edge.
REQ-002 SHALL have ports: reset  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports: i_address  input  32,  i_enable  input  1  instruction fetch request.
REQ-004 SHALL have ports: i_instruction  output  32  fetch data,  i_stall  output  1  fetch not complete.
REQ-005 SHALL have ports: d_address  input  32,  d_byteenable  input  4,  d_read  input  1,  d_write  input  1,  d_writedata  input  32.
REQ-006 SHALL have ports: d_readdata  output  32  load data,  d_stall  output  1  data access not complete.
REQ-007 SHALL have ports: m_req  output  1,  m_we  output  1,  m_address  output  32,  m_byteenable  output  4,  m_writedata  output  32  memory request.
REQ-008 SHALL have ports: m_ack  input  1  transfer-complete pulse,  m_rdata  input  32  read data, valid when m_ack=1.

Function
REQ-009 SHALL share the single memory port between the fetch and data requesters, with at most one transaction outstanding.
REQ-010 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-011 SHALL, in IDLE with only i_enable=1, capture i_address, m_we=0 and byteenable 4'hF, then go to BUSY_I.
REQ-012 SHALL, in IDLE with only d_read or d_write=1, capture the d_* fields, then go to BUSY_D.
REQ-013 SHALL, in IDLE with both requesting, grant per the REQ-027/028 policy.
REQ-014 SHALL drive m_req=1 in BUSY_I/BUSY_D from registered fields held stable until m_ack; m_req=0 in IDLE.
REQ-015 SHALL set m_we=1 when d_write=1, including when d_read=1 at the same time (write wins).
REQ-016 SHALL return to IDLE on m_ack in a BUSY state; a new grant is evaluated in the following cycle.
REQ-017 SHALL set i_stall = i_enable AND NOT(state==BUSY_I AND m_ack), combinationally.
REQ-018 SHALL set d_stall = (d_read OR d_write) AND NOT(state==BUSY_D AND m_ack), combinationally.
REQ-019 SHALL pass i_instruction = m_rdata and d_readdata = m_rdata combinationally; they are valid only in the owner's ack cycle.
REQ-020 SHALL give minimum latency of request at cycle N (IDLE), m_req at N+1, and stall low at N+1 if m_ack=1 at N+1.
REQ-021 SHALL hold requester inputs stable while stalled; changes during BUSY are ignored until the next IDLE grant.
REQ-022 SHALL ignore m_ack in IDLE, with no state change and no stall release.
REQ-023 SHALL keep a requester that deasserts while BUSY for its own transaction on the bus until m_ack, with the result discarded.

Reset
REQ-024 SHALL, on reset asserted (asynchronously), go to state IDLE with m_req=0, m_we=0, m_address=0, m_byteenable=0, m_writedata=0, and last-grant flag=fetch.
REQ-025 SHALL drive i_stall and d_stall from the REQ-017/018 equations during reset, so they equal the request inputs.
REQ-026 SHALL abandon any in-flight transaction on reset mid-operation; a late m_ack after reset is ignored per REQ-022.

Configuration
REQ-027 SHALL, with macro MEM_ARB_ROUND_ROBIN_EN defined, grant on contention to the requester not granted last; the last-grant flag updates on every grant.
REQ-028 SHALL, with MEM_ARB_ROUND_ROBIN_EN undefined, grant on contention to data (fixed priority), with no last-grant flag.

Verification
REQ-029 SHALL be covered by: single fetch i_enable=1, i_address=0x100, m_ack at first m_req cycle -> m_address=0x100, m_we=0, byteenable F, i_stall low one cycle after request, i_instruction=m_rdata.
REQ-030 SHALL be covered by: store d_write=1, addr 0x2004, be=4'b0011, wdata 0xDEADBEEF, m_ack after 3 wait cycles -> m_we=1 fields stable 4 cycles, d_stall high until ack cycle.
REQ-031 SHALL be covered by: fetch and load both pending for 4 transactions, immediate acks -> with RR order D,I,D,I (flag reset=fetch); without RR order D,D then I after data drops.
REQ-032 SHALL be covered by: d_read=1 and d_write=1 together -> m_we=1.
REQ-033 SHALL be covered by: reset asserted in BUSY_D, then m_ack=1 one cycle after release -> IDLE, m_req=0 immediately, late ack ignored, d_stall stays high if d_read held.
REQ-034 SHALL be covered by: i_address changed mid BUSY_I -> m_address keeps captured value until m_ack.
